// File: rtl/trf_wb_arb_pkg.sv
// Shared types and constants for the TRF write-back arbiter: PU write request,
// 4-thread TRF write beat and the hold-register phase encoding.
package trf_wb_arb_pkg;

    localparam int WRPU_N = 7;
    localparam int THD_DW = 32;
    localparam int THDB_N = 8;

    typedef struct packed {
        logic [7:0]  tmask;
        logic [31:0] bmask;
        logic [9:0]  waddr;
        logic        bgrpid;
    } pu_wr_trf_t;

    typedef struct packed {
        logic [3:0]             tmask;
        logic [31:0]            bmask;
        logic [10:0]            waddr;
        logic                   bgrpid;
        logic [3:0][THD_DW-1:0] wdata;
    } wr_trf_thd4_wr_t;

    typedef enum logic [1:0] {
        WB_PHASE_IDLE = 2'd0,
        WB_PHASE_LO   = 2'd1,
        WB_PHASE_HI   = 2'd2
    } wb_phase_e;

endpackage

// File: rtl/trf_wb_rr_arb.sv
// N-way round-robin arbiter: the first asserted request at or after ptr wins;
// produces a one-hot grant and its binary index.
module trf_wb_rr_arb #(
    parameter int N  = 7,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!gnt_any && req[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trf_wb_arb.sv
// TRF write-back arbiter: grants one 8-thread PU write per cycle (round-robin)
// and emits it as low/high 4-thread TRF beats. Define TRF_WB_CNT_EN for perf counters.
module trf_wb_arb #(
    parameter int WRPU_N = trf_wb_arb_pkg::WRPU_N,
    parameter int THD_DW = trf_wb_arb_pkg::THD_DW
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [WRPU_N-1:0]                      pu_vld,
    output logic [WRPU_N-1:0]                      pu_rdy,
    input  trf_wb_arb_pkg::pu_wr_trf_t [WRPU_N-1:0] pu_req,
    input  logic [WRPU_N-1:0][7:0][THD_DW-1:0]     pu_wdata,
    output logic                                   trf_vld,
    input  logic                                   trf_rdy,
    output trf_wb_arb_pkg::wr_trf_thd4_wr_t        trf_wr,
`ifdef TRF_WB_CNT_EN
    output logic [31:0]                            cnt_beat,
    output logic [31:0]                            cnt_stall,
`endif
    output logic [2:0]                             trf_puid
);
    import trf_wb_arb_pkg::*;

    localparam int IW = (WRPU_N > 1) ? $clog2(WRPU_N) : 1;

    wb_phase_e            state_q, state_d;
    logic [IW-1:0]        rr_ptr_q;
    pu_wr_trf_t           hr_req;
    logic [7:0][THD_DW-1:0] hr_data;
    logic [2:0]           hr_puid;

    logic [WRPU_N-1:0]    gnt_oh;
    logic [IW-1:0]        gnt_idx;
    logic                 gnt_any;
    logic                 can_grant;
    logic                 grant;
    logic                 hi_pend;
    logic [7:0]           gnt_tmask;

    trf_wb_rr_arb #(.N(WRPU_N), .IW(IW)) u_rr_arb (
        .req     (pu_vld),
        .ptr     (rr_ptr_q),
        .gnt     (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign hi_pend   = |hr_req.tmask[7:4];
    assign gnt_tmask = pu_req[gnt_idx].tmask;

    // A new grant may land in the same cycle the final beat of the held request drains.
    always_comb begin
        can_grant = 1'b0;
        case (state_q)
            WB_PHASE_IDLE: can_grant = 1'b1;
            WB_PHASE_LO:   can_grant = trf_rdy && !hi_pend;
            WB_PHASE_HI:   can_grant = trf_rdy;
            default:       can_grant = 1'b0;
        endcase
    end

    assign grant  = can_grant && gnt_any;
    assign pu_rdy = gnt_oh & {WRPU_N{can_grant}};

    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_PHASE_LO: if (trf_rdy) state_d = hi_pend ? WB_PHASE_HI : WB_PHASE_IDLE;
            WB_PHASE_HI: if (trf_rdy) state_d = WB_PHASE_IDLE;
            WB_PHASE_IDLE: state_d = WB_PHASE_IDLE;
            default:     state_d = WB_PHASE_IDLE;
        endcase
        // An all-zero tmask is consumed without ever producing a beat.
        if (grant) begin
            if (|gnt_tmask[3:0])      state_d = WB_PHASE_LO;
            else if (|gnt_tmask[7:4]) state_d = WB_PHASE_HI;
            else                      state_d = WB_PHASE_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WB_PHASE_IDLE;
            rr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) rr_ptr_q <= (gnt_idx == IW'(WRPU_N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hr_req  <= '0;
            hr_data <= '0;
            hr_puid <= '0;
        end else if (grant) begin
            hr_req  <= pu_req[gnt_idx];
            hr_data <= pu_wdata[gnt_idx];
            hr_puid <= 3'(gnt_idx);
        end
    end

    assign trf_vld  = (state_q != WB_PHASE_IDLE);
    assign trf_puid = hr_puid;

    always_comb begin
        trf_wr        = '0;
        trf_wr.bmask  = hr_req.bmask;
        trf_wr.bgrpid = hr_req.bgrpid;
        if (state_q == WB_PHASE_HI) begin
            trf_wr.tmask = hr_req.tmask[7:4];
            trf_wr.waddr = {1'b1, hr_req.waddr};
            trf_wr.wdata = hr_data[7:4];
        end else begin
            trf_wr.tmask = hr_req.tmask[3:0];
            trf_wr.waddr = {1'b0, hr_req.waddr};
            trf_wr.wdata = hr_data[3:0];
        end
    end

`ifdef TRF_WB_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_beat  <= '0;
            cnt_stall <= '0;
        end else if (trf_vld) begin
            if (trf_rdy) cnt_beat  <= sat_inc(cnt_beat);
            else         cnt_stall <= sat_inc(cnt_stall);
        end
    end
`endif

endmodule
